// File: rtl/cmp_scheduler_if.sv
// cmp_scheduler_if: requester request/response bus plus the shared comparator's operand,
// control and result signals, as seen by the scheduler (slave) and its environment (master).
interface cmp_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_l;
    logic                  rsp_e;
    logic                  rsp_g;
    logic                  rsp_err;
    logic                  busy;
    logic                  cmp_load;
    logic [WIDTH-1:0]      cmp_a;
    logic [WIDTH-1:0]      cmp_b;
    logic                  cmp_l;
    logic                  cmp_e;
    logic                  cmp_g;
    logic                  cmp_op;
    modport slave (
        input  req, a_bus, b_bus, cmp_l, cmp_e, cmp_g, cmp_op,
        output gnt, rsp_valid, rsp_l, rsp_e, rsp_g, rsp_err, busy, cmp_load, cmp_a, cmp_b
    );
    modport master (
        output req, a_bus, b_bus, cmp_l, cmp_e, cmp_g, cmp_op,
        input  gnt, rsp_valid, rsp_l, rsp_e, rsp_g, rsp_err, busy, cmp_load, cmp_a, cmp_b
    );
endinterface

// File: rtl/cmp_scheduler.sv
// cmp_scheduler: round-robin sharing of one multi-cycle comparator among NREQ requesters.
module cmp_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input logic             clk,
    input logic             rst_n,
    cmp_scheduler_if.slave  sif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, owner_q, owner_d, sel;
    logic             found;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       rsp_q, rsp_d;
    logic [2:0]       leg;
    assign leg = {sif.cmp_l, sif.cmp_e, sif.cmp_g};
    // scanning downward lets the requester nearest at/after the pointer win
    always_comb begin
        int idx;
        sel   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (sif.req[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOAD;
                owner_d = sel;
                a_d     = sif.a_bus[sel*WIDTH +: WIDTH];
                b_d     = sif.b_bus[sel*WIDTH +: WIDTH];
            end
            LOAD: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                // a done flag seen in the first RUN cycle is left over from the previous operation
                if (sif.cmp_op && timer_q != '0) begin
                    state_d = DONE;
                    rsp_d   = {leg, !$onehot(leg)};
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    rsp_d   = 4'b0001;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rsp_q   <= rsp_d;
        end
    end
    assign sif.gnt       = (state_q == IDLE && found) ? ({{(NREQ-1){1'b0}}, 1'b1} << sel) : '0;
    assign sif.rsp_valid = (state_q == DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign {sif.rsp_l, sif.rsp_e, sif.rsp_g, sif.rsp_err} = rsp_q;
    assign sif.busy      = state_q != IDLE;
    assign sif.cmp_load  = state_q == LOAD;
    assign sif.cmp_a     = a_q;
    assign sif.cmp_b     = b_q;
endmodule

// File: doc/cmp_scheduler.md
Name: cmp_scheduler

Overview:
- Round-robin scheduler that shares one multi-cycle 32-bit sequential comparator among NREQ requesters.
- Arbitrates requests, captures the granted operands and drives the comparator's load/run protocol.
- Waits for the comparator's done flag (OP), then returns the L/E/G result to the owning requester.
- Sits between the requester clients and the single comparator instance; the only block that drives the comparator's operand and control inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand width
TIMEOUT, 40, max RUN cycles waiting for cmp_op before error (must exceed comparator latency)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request, level, held until gnt
a_bus  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
b_bus  in  NREQ*WIDTH  operand B, same packing
gnt  out  NREQ  one-hot, one-cycle pulse: request accepted, operands captured
rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i
rsp_l  out  1  A<B, valid with rsp_valid
rsp_e  out  1  A==B, valid with rsp_valid
rsp_g  out  1  A>B, valid with rsp_valid
rsp_err  out  1  timeout or non-one-hot comparator result, valid with rsp_valid
busy  out  1  high in any state other than IDLE
cmp_load  out  1  to comparator input_signal: 1=load operands, 0=run
cmp_a  out  WIDTH  registered operand A to comparator
cmp_b  out  WIDTH  registered operand B to comparator
cmp_l  in  1  comparator L
cmp_e  in  1  comparator E
cmp_g  in  1  comparator G
cmp_op  in  1  comparator done flag

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt, rsp_valid, rsp_l/e/g, rsp_err, busy, cmp_load = 0; cmp_a/cmp_b = 0; rr pointer=0; timer=0; any in-flight request is dropped with no rsp_valid.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req!=0, select the first asserted req at or after the pointer, wrapping modulo NREQ.
  - Pulse gnt[sel] in this cycle (combinational from registered state plus req).
  - On the edge, register owner=sel and cmp_a/cmp_b from the selected slices; go to LOAD.
  - If req==0, stay in IDLE.
- LOAD: cmp_load=1 for exactly one cycle; timer cleared; go to RUN.
- RUN:
  - cmp_load=0; timer increments each cycle.
  - cmp_op is ignored in the first RUN cycle (stale-done guard).
  - From the second RUN cycle, cmp_op=1 captures cmp_l/e/g. rsp_err=1 if {l,e,g} is not one-hot. Go to DONE.
  - If timer reaches TIMEOUT with no cmp_op: l/e/g=0, rsp_err=1, go to DONE.
  - If cmp_op and timeout occur in the same cycle, cmp_op wins.
- DONE:
  - rsp_valid[owner]=1 for one cycle with registered rsp_l/e/g/rsp_err.
  - Pointer = (owner+1) mod NREQ. Go to IDLE.
- rsp_l/e/g/rsp_err hold their values until the next DONE.
- busy=1 in LOAD, RUN and DONE.
- Throughput: the next grant can occur in the IDLE cycle immediately after DONE. There is no grant while busy.
- Requester rules:
  - req and operands must stay stable until gnt.
  - Operands may change the cycle after gnt.
  - req still high after gnt is treated as a new request.
  - A requester whose req drops before gnt is simply not served.
- Fairness: a continuously requesting client waits at most NREQ-1 other operations.
- cmp_a/cmp_b are stable from LOAD through DONE.

Test Plan:
- Single req[0], A=0xCA88A888, B=0xA88A8888 -> gnt[0] pulse, one cmp_load cycle, then rsp_valid[0] with G=1, L=0, E=0, err=0.
- req[2] with A=B=0x12345678 -> rsp_valid[2], E=1. Then req[2] with A=5, B=9 -> L=1.
- req=4'b1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3; no two gnt in the same cycle; each rsp_valid matches its grant index.
- Comparator model never asserts cmp_op -> rsp_valid after TIMEOUT=40 RUN cycles with err=1, l/e/g=0; the next request is still served normally.
- Comparator returns L=1 and G=1 together -> rsp_err=1.
- rst driven low mid-RUN (between clock edges) -> outputs clear immediately; no rsp_valid for the dropped request; after release, req[1] is granted first (pointer=0, only req[1] asserted).
